// File: rtl/scm_arb_pkg.sv
// Shared types and sizing helpers for the 1R1W register-file port arbiter.
// No logic, no latency.
// No backpressure.
package scm_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    localparam int ADDR_WIDTH_DEF = 5;
    localparam int NUM_WORDS_DEF  = 2 ** ADDR_WIDTH_DEF;
    localparam int NR_DEF         = 4;
    localparam int NW_DEF         = 2;

    // Index width that stays legal for a single-requester arbiter.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int RD_PTR_W_DEF = ptr_width(NR_DEF);
    localparam int WR_PTR_W_DEF = ptr_width(NW_DEF);

endpackage

// File: rtl/register_file_1r_1w_ff.sv
// Flip-flop register file, one read port and one write port.
// Latency: read address registered, data one cycle later; the write on that edge is visible.
// No backpressure.
module register_file_1r_1w_ff #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  ReadEnable,
    input  logic [ADDR_WIDTH-1:0] ReadAddr,
    output logic [DATA_WIDTH-1:0] ReadData,
    input  logic                  WriteEnable,
    input  logic [ADDR_WIDTH-1:0] WriteAddr,
    input  logic [DATA_WIDTH-1:0] WriteData
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] raddr_q;

    always_ff @(posedge clk) begin
        if (WriteEnable) begin
            mem[WriteAddr] <= WriteData;
        end
        if (ReadEnable) begin
            raddr_q <= ReadAddr;
        end
    end

    // Combinational read behind the address register gives write-first collisions.
    assign ReadData = mem[raddr_q];

endmodule

// File: rtl/scm_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer.
// Latency: combinational grant, pointer moves past the winner on the grant edge.
// Backpressure: en low suppresses every grant and freezes the pointer.
module scm_rr_arbiter
    import scm_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = ptr_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] ptr;
    logic          found;
    int            j;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (en && !found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/scm_1r_1w_port_arbiter.sv
// Shares the RF read and write ports among NR readers / NW writers, plus a zero-fill sweep.
// Latency: grant same cycle, read response one cycle later; sweep takes NUM_WORDS cycles.
// Backpressure: requests hold until granted; no grants during a sweep; responses cannot stall.
module scm_1r_1w_port_arbiter
    import scm_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NR         = 4,
    parameter int NW         = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NR-1:0]              rd_req_i,
    input  logic [NR*ADDR_WIDTH-1:0]   rd_addr_i,
    output logic [NR-1:0]              rd_gnt_o,
    output logic [NR-1:0]              rd_rvalid_o,
    output logic [DATA_WIDTH-1:0]      rd_rdata_o,
    input  logic [NW-1:0]              wr_req_i,
    input  logic [NW*ADDR_WIDTH-1:0]   wr_addr_i,
    input  logic [NW*DATA_WIDTH-1:0]   wr_data_i,
    output logic [NW-1:0]              wr_gnt_o,
    input  logic                       clear_req_i,
    output logic                       clear_busy_o,
    output logic                       clear_done_o,
    output logic                       rf_ren_o,
    output logic [ADDR_WIDTH-1:0]      rf_raddr_o,
    input  logic [DATA_WIDTH-1:0]      rf_rdata_i,
    output logic                       rf_wen_o,
    output logic [ADDR_WIDTH-1:0]      rf_waddr_o,
    output logic [DATA_WIDTH-1:0]      rf_wdata_o
);

    localparam int NUM_WORDS = 2 ** ADDR_WIDTH;
    localparam int RPW       = ptr_width(NR);
    localparam int WPW       = ptr_width(NW);

    state_e                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] raddr_q;
    logic                  arb_en;
    logic                  last_word;
    logic [RPW-1:0]        rd_idx;
    logic [WPW-1:0]        wr_idx;

    // Grants are also forced low while reset is held.
    assign arb_en    = (state == IDLE) && !rst;
    assign last_word = (cnt == ADDR_WIDTH'(NUM_WORDS - 1));

    scm_rr_arbiter #(.N(NR)) u_rd_arb (
        .clk (clk),
        .rst (rst),
        .en  (arb_en),
        .req (rd_req_i),
        .gnt (rd_gnt_o),
        .idx (rd_idx)
    );

    scm_rr_arbiter #(.N(NW)) u_wr_arb (
        .clk (clk),
        .rst (rst),
        .en  (arb_en),
        .req (wr_req_i),
        .gnt (wr_gnt_o),
        .idx (wr_idx)
    );

    assign rf_ren_o     = |rd_gnt_o;
    assign rf_raddr_o   = rf_ren_o ? rd_addr_i[int'(rd_idx)*ADDR_WIDTH +: ADDR_WIDTH] : raddr_q;
    assign rd_rdata_o   = rf_rdata_i;
    assign clear_busy_o = (state == CLEAR);

    always_comb begin
        rf_wen_o   = |wr_gnt_o;
        rf_waddr_o = wr_addr_i[int'(wr_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        rf_wdata_o = wr_data_i[int'(wr_idx)*DATA_WIDTH +: DATA_WIDTH];
        if (state == CLEAR) begin
            rf_wen_o   = 1'b1;
            rf_waddr_o = cnt;
            rf_wdata_o = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            raddr_q      <= '0;
            rd_rvalid_o  <= '0;
            clear_done_o <= 1'b0;
        end else begin
            rd_rvalid_o  <= rd_gnt_o;
            clear_done_o <= 1'b0;
            if (rf_ren_o) begin
                raddr_q <= rf_raddr_o;
            end
            case (state)
                IDLE: begin
                    if (clear_req_i) begin
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (last_word) begin
                        cnt          <= '0;
                        state        <= IDLE;
                        clear_done_o <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
